pong_engine: RTL and testbench

PONG_ENGINE -- requirements
Module: pong_engine

---
 rtl/pong_pkg.sv | 22 ++
 rtl/pong_tick_gen.sv | 29 ++
 rtl/pong_engine.sv | 198 +++++++++++++++++++
 tb/tb_pong_engine.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared encodings for the pong game engine.
// State, winner and ball direction constants.
package pong_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SERVE = 2'd1,
        ST_PLAY  = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WIN_NONE = 2'd0,
        WIN_P1   = 2'd1,
        WIN_P2   = 2'd2
    } winner_t;

    // One direction bit per axis: 0 moves +1, 1 moves -1
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

endpackage

// File: rtl/pong_tick_gen.sv
// Free-running game tick divider.
// Pulses for one cycle when the count reaches TICK_DIV-1.
module pong_tick_gen #(
    parameter int TICK_DIV = 400000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] r_cnt;

    // Count 0..TICK_DIV-1 and wrap
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == LAST);

endmodule

// File: rtl/pong_engine.sv
// Two-player pong game engine: paddles, ball, scores.
// Everything but start/restart advances on the game tick.
module pong_engine
    import pong_pkg::*;
#(
    parameter int TICK_DIV  = 400000,
    parameter int FIELD_W   = 160,
    parameter int FIELD_H   = 128,
    parameter int PADDLE_H  = 10,
    parameter int SCORE_W   = 3,
    parameter int WIN_SCORE = 7
) (
    input  logic                       Clock,
    input  logic                       Reset,
    input  logic                       isEnter,
    input  logic                       isZ,
    input  logic                       isX,
    input  logic                       isLeft,
    input  logic                       isRight,
    output logic [$clog2(FIELD_H)-1:0] P1Position,
    output logic [$clog2(FIELD_H)-1:0] P2Position,
    output logic [$clog2(FIELD_W)-1:0] BallX,
    output logic [$clog2(FIELD_H)-1:0] BallY,
    output logic [SCORE_W-1:0]         Score1,
    output logic [SCORE_W-1:0]         Score2,
    output logic [1:0]                 State,
    output logic [1:0]                 Winner,
    output logic                       Tick
);

    localparam int XW = $clog2(FIELD_W);
    localparam int YW = $clog2(FIELD_H);

    localparam logic [XW-1:0] X_CTR = XW'(FIELD_W / 2);
    localparam logic [XW-1:0] X_MAX = XW'(FIELD_W - 1);
    localparam logic [XW-1:0] X_ONE = XW'(1);
    localparam logic [XW-1:0] X_TWO = XW'(2);
    localparam logic [XW-1:0] X_P2  = XW'(FIELD_W - 2);
    localparam logic [XW-1:0] X_P2B = XW'(FIELD_W - 3);

    localparam logic [YW-1:0] Y_CTR    = YW'(FIELD_H / 2);
    localparam logic [YW-1:0] Y_MAX    = YW'(FIELD_H - 1);
    localparam logic [YW-1:0] PAD_MAX  = YW'(FIELD_H - PADDLE_H);
    localparam logic [YW-1:0] PAD_RST  = YW'((FIELD_H - PADDLE_H) / 2);
    localparam logic [YW-1:0] PAD_SPAN = YW'(PADDLE_H - 1);

    localparam logic [SCORE_W-1:0] S_WIN = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] S_MAX = '1;

    state_t            r_state;
    winner_t           r_winner;
    logic [YW-1:0]     r_p1, r_p2, r_by;
    logic [XW-1:0]     r_bx;
    logic              r_dx, r_dy;
    logic [SCORE_W-1:0] r_s1, r_s2;

    logic              w_tick;
    logic [YW-1:0]     w_p1_nxt, w_p2_nxt, w_by_nxt;
    logic [XW-1:0]     w_bx_nxt;
    logic              w_dx_nxt, w_dy_nxt, w_dy_flip;
    logic              w_p1_hit, w_p2_hit, w_p1_bounce, w_p2_bounce;
    logic              w_miss1, w_miss2;
    logic [SCORE_W-1:0] w_s1_inc, w_s2_inc;

    pong_tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .i_clk   (Clock),
        .i_rst_n (Reset),
        .o_tick  (w_tick)
    );

    // Up alone moves -1, down alone +1, clamped to the field
    function automatic logic [YW-1:0] paddle_step(
        input logic [YW-1:0] pos,
        input logic          up,
        input logic          dn
    );
        logic [YW-1:0] res;
        res = pos;
        if (up && !dn && pos != '0) begin
            res = pos - 1'b1;
        end else if (dn && !up && pos < PAD_MAX) begin
            res = pos + 1'b1;
        end
        return res;
    endfunction

    assign w_p1_nxt = paddle_step(r_p1, isZ, isX);
    assign w_p2_nxt = paddle_step(r_p2, isLeft, isRight);

    assign w_dy_flip = (r_by == '0 && r_dy == DIR_NEG) ||
                       (r_by == Y_MAX && r_dy == DIR_POS);
    assign w_dy_nxt  = w_dy_flip ? ~r_dy : r_dy;
    assign w_by_nxt  = (w_dy_nxt == DIR_POS) ? r_by + 1'b1 : r_by - 1'b1;

    // Hit windows use the paddle positions before this tick
    assign w_p1_hit = (r_by >= r_p1) && (r_by <= r_p1 + PAD_SPAN);
    assign w_p2_hit = (r_by >= r_p2) && (r_by <= r_p2 + PAD_SPAN);
    assign w_p1_bounce = (r_bx == X_ONE) && (r_dx == DIR_NEG) && w_p1_hit;
    assign w_p2_bounce = (r_bx == X_P2) && (r_dx == DIR_POS) && w_p2_hit;

    assign w_miss1 = (r_bx == '0) && (r_dx == DIR_NEG);
    assign w_miss2 = (r_bx == X_MAX) && (r_dx == DIR_POS);

    assign w_s1_inc = (r_s1 == S_MAX) ? r_s1 : r_s1 + 1'b1;
    assign w_s2_inc = (r_s2 == S_MAX) ? r_s2 : r_s2 + 1'b1;

    // Horizontal motion with paddle reflection
    always_comb begin
        w_bx_nxt = r_bx;
        w_dx_nxt = r_dx;
        if (w_p1_bounce) begin
            w_bx_nxt = X_TWO;
            w_dx_nxt = DIR_POS;
        end else if (w_p2_bounce) begin
            w_bx_nxt = X_P2B;
            w_dx_nxt = DIR_NEG;
        end else if (r_dx == DIR_POS) begin
            w_bx_nxt = r_bx + 1'b1;
        end else begin
            w_bx_nxt = r_bx - 1'b1;
        end
    end

    // Game FSM; restart from OVER shares the reset path
    always_ff @(posedge Clock) begin
        if (!Reset || (r_state == ST_OVER && isEnter)) begin
            r_state  <= ST_IDLE;
            r_winner <= WIN_NONE;
            r_s1     <= '0;
            r_s2     <= '0;
            r_p1     <= PAD_RST;
            r_p2     <= PAD_RST;
            r_bx     <= X_CTR;
            r_by     <= Y_CTR;
            r_dx     <= DIR_POS;
            r_dy     <= DIR_POS;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (isEnter) r_state <= ST_SERVE;
                end
                ST_SERVE: begin
                    r_bx <= X_CTR;
                    r_by <= Y_CTR;
                    r_dy <= DIR_POS;
                    if (w_tick) r_state <= ST_PLAY;
                end
                ST_PLAY: begin
                    if (w_tick) begin
                        r_p1 <= w_p1_nxt;
                        r_p2 <= w_p2_nxt;
                        if (w_miss1 || w_miss2) begin
                            r_bx <= X_CTR;
                            r_by <= Y_CTR;
                            r_dy <= DIR_POS;
                            r_state <= ST_SERVE;
                        end
                        if (w_miss1) begin
                            r_s2 <= w_s2_inc;
                            r_dx <= DIR_NEG;
                            if (w_s2_inc == S_WIN) begin
                                r_state  <= ST_OVER;
                                r_winner <= WIN_P2;
                            end
                        end else if (w_miss2) begin
                            r_s1 <= w_s1_inc;
                            r_dx <= DIR_POS;
                            if (w_s1_inc == S_WIN) begin
                                r_state  <= ST_OVER;
                                r_winner <= WIN_P1;
                            end
                        end else begin
                            r_bx <= w_bx_nxt;
                            r_dx <= w_dx_nxt;
                            r_by <= w_by_nxt;
                            r_dy <= w_dy_nxt;
                        end
                    end
                end
                ST_OVER: begin
                end
            endcase
        end
    end

    assign P1Position = r_p1;
    assign P2Position = r_p2;
    assign BallX      = r_bx;
    assign BallY      = r_by;
    assign Score1     = r_s1;
    assign Score2     = r_s2;
    assign State      = r_state;
    assign Winner     = r_winner;
    assign Tick       = w_tick;

endmodule

// File: tb/tb_pong_engine.sv
// Testbench for pong_engine with a small field.
// Scoreboard of per-tick snapshots from an integer game model.
module tb_pong_engine;

    localparam int TD = 4;
    localparam int FW = 16;
    localparam int FH = 16;
    localparam int PH = 4;
    localparam int SW = 3;
    localparam int WS = 2;

    logic Clock, Reset, isEnter, isZ, isX, isLeft, isRight;
    logic [3:0] P1Position, P2Position, BallX, BallY;
    logic [2:0] Score1, Score2;
    logic [1:0] State, Winner;
    logic Tick;

    typedef struct packed {
        logic [1:0] st;
        logic [1:0] win;
        logic [3:0] p1;
        logic [3:0] p2;
        logic [3:0] bx;
        logic [3:0] by;
        logic [2:0] s1;
        logic [2:0] s2;
    } snap_t;

    snap_t exp_q[$];
    snap_t got_q[$];
    int n_checks = 0;
    int n_errors = 0;

    int m_st, m_win, m_p1, m_p2, m_bx, m_by, m_dx, m_dy, m_s1, m_s2;

    pong_engine #(
        .TICK_DIV  (TD),
        .FIELD_W   (FW),
        .FIELD_H   (FH),
        .PADDLE_H  (PH),
        .SCORE_W   (SW),
        .WIN_SCORE (WS)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .isEnter    (isEnter),
        .isZ        (isZ),
        .isX        (isX),
        .isLeft     (isLeft),
        .isRight    (isRight),
        .P1Position (P1Position),
        .P2Position (P2Position),
        .BallX      (BallX),
        .BallY      (BallY),
        .Score1     (Score1),
        .Score2     (Score2),
        .State      (State),
        .Winner     (Winner),
        .Tick       (Tick)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    function automatic snap_t sample();
        snap_t s;
        s.st = State;      s.win = Winner;
        s.p1 = P1Position; s.p2 = P2Position;
        s.bx = BallX;      s.by = BallY;
        s.s1 = Score1;     s.s2 = Score2;
        return s;
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.st = 2'(m_st);  s.win = 2'(m_win);
        s.p1 = 4'(m_p1);  s.p2 = 4'(m_p2);
        s.bx = 4'(m_bx);  s.by = 4'(m_by);
        s.s1 = 3'(m_s1);  s.s2 = 3'(m_s2);
        return s;
    endfunction

    function automatic snap_t reset_snap();
        snap_t s;
        s.st = 2'd0; s.win = 2'd0;
        s.p1 = 4'd6; s.p2 = 4'd6;
        s.bx = 4'd8; s.by = 4'd8;
        s.s1 = 3'd0; s.s2 = 3'd0;
        return s;
    endfunction

    function automatic string fmt(snap_t s);
        return $sformatf("st=%0d win=%0d p1=%0d p2=%0d ball=(%0d,%0d) sc=%0d:%0d",
                         s.st, s.win, s.p1, s.p2, s.bx, s.by, s.s1, s.s2);
    endfunction

    function automatic int clampp(int v);
        if (v < 0) return 0;
        if (v > FH - PH) return FH - PH;
        return v;
    endfunction

    task automatic model_reset();
        m_st = 0; m_win = 0; m_p1 = 6; m_p2 = 6;
        m_bx = 8; m_by = 8; m_dx = 1; m_dy = 1;
        m_s1 = 0; m_s2 = 0;
    endtask

    task automatic model_enter();
        if (m_st == 0) m_st = 1;
        else if (m_st == 3) model_reset();
    endtask

    task automatic model_tick(input bit z, input bit x, input bit l, input bit r);
        int op1, op2, obx, oby;
        op1 = m_p1; op2 = m_p2; obx = m_bx; oby = m_by;
        if (m_st == 1) begin
            m_st = 2;
        end else if (m_st == 2) begin
            m_p1 = clampp(op1 + ((x && !z) ? 1 : 0) - ((z && !x) ? 1 : 0));
            m_p2 = clampp(op2 + ((r && !l) ? 1 : 0) - ((l && !r) ? 1 : 0));
            if (obx == 0 && m_dx < 0) begin
                m_s2++;
                m_st = (m_s2 == WS) ? 3 : 1;
                if (m_s2 == WS) m_win = 2;
                m_bx = FW / 2; m_by = FH / 2; m_dx = -1; m_dy = 1;
            end else if (obx == FW - 1 && m_dx > 0) begin
                m_s1++;
                m_st = (m_s1 == WS) ? 3 : 1;
                if (m_s1 == WS) m_win = 1;
                m_bx = FW / 2; m_by = FH / 2; m_dx = 1; m_dy = 1;
            end else begin
                if ((oby == 0 && m_dy < 0) || (oby == FH - 1 && m_dy > 0))
                    m_dy = -m_dy;
                m_by = oby + m_dy;
                if (obx == 1 && m_dx < 0 && oby >= op1 && oby <= op1 + PH - 1) begin
                    m_dx = 1; m_bx = 2;
                end else if (obx == FW - 2 && m_dx > 0 &&
                             oby >= op2 && oby <= op2 + PH - 1) begin
                    m_dx = -1; m_bx = FW - 3;
                end else begin
                    m_bx = obx + m_dx;
                end
            end
        end
    endtask

    // Input schedule indexed by game tick number
    task automatic set_inputs(input int k);
        isZ     = (k >= 1 && k <= 7) || k == 27 || k == 28;
        isX     = (k >= 21 && k <= 26) || k == 27 || k == 28;
        isRight = (k >= 1 && k <= 7);
        isLeft  = (k >= 21 && k <= 25) || k == 47;
        isEnter = (k == 30);
    endtask

    task automatic wait_tick();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge Clock);
            if (Tick === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL tick_timeout: Tick=0 required 1");
        end else begin
            @(posedge Clock);
            #1;
        end
    endtask

    task automatic run_ticks(input int from, input int to);
        for (int k = from; k <= to; k++) begin
            set_inputs(k);
            model_tick(isZ, isX, isLeft, isRight);
            exp_q.push_back(model_snap());
            wait_tick();
            got_q.push_back(sample());
        end
        set_inputs(-1);
    endtask

    task automatic pulse_enter();
        @(negedge Clock);
        isEnter = 1'b1;
        @(posedge Clock);
        #1;
        isEnter = 1'b0;
        model_enter();
    endtask

    task automatic test_reset();
        snap_t g;
        Reset = 1'b0;
        set_inputs(-1);
        model_reset();
        repeat (3) @(posedge Clock);
        #1;
        g = sample();
        n_checks++;
        if (g !== reset_snap()) begin
            n_errors++;
            $display("FAIL reset_values: got %s required %s", fmt(g), fmt(reset_snap()));
        end
        n_checks++;
        if (Tick !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_tick: got %0b required 0", Tick);
        end
        Reset = 1'b1;
        for (int k = 0; k < 8; k++) begin
            logic want;
            @(negedge Clock);
            want = ((k % 4) == 3);
            n_checks++;
            if (Tick !== want) begin
                n_errors++;
                $display("FAIL tick_period[%0d]: got %0b required %0b", k, Tick, want);
            end
        end
    endtask

    task automatic test_serve();
        snap_t e, g;
        pulse_enter();
        n_checks++;
        if (State !== 2'd1) begin
            n_errors++;
            $display("FAIL enter_to_serve: got %0d required 1", State);
        end
        run_ticks(0, 1);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL serve_tick: got %s required %s", fmt(g), fmt(e));
            end
        end
        n_checks++;
        if (State !== 2'd2 || BallX !== 4'd9 || BallY !== 4'd9) begin
            n_errors++;
            $display("FAIL first_move: got st=%0d ball=(%0d,%0d) required st=2 ball=(9,9)",
                     State, BallX, BallY);
        end
    endtask

    task automatic test_paddles();
        snap_t e, g;
        run_ticks(2, 5);
        n_checks++;
        if (P1Position !== 4'd1) begin
            n_errors++;
            $display("FAIL p1_at_one: got %0d required 1", P1Position);
        end
        run_ticks(6, 7);
        n_checks++;
        if (P1Position !== 4'd0 || P2Position !== 4'd12) begin
            n_errors++;
            $display("FAIL paddle_clamp: got p1=%0d p2=%0d required p1=0 p2=12",
                     P1Position, P2Position);
        end
        run_ticks(8, 28);
        n_checks++;
        if (P1Position !== 4'd6) begin
            n_errors++;
            $display("FAIL both_held: got %0d required 6", P1Position);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL paddle_tick: got %s required %s", fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_p1_hit();
        snap_t e, g;
        run_ticks(29, 45);
        n_checks++;
        if (BallX !== 4'd1 || BallY !== 4'd7 || P1Position !== 4'd6) begin
            n_errors++;
            $display("FAIL hit_setup: got ball=(%0d,%0d) p1=%0d required (1,7) p1=6",
                     BallX, BallY, P1Position);
        end
        run_ticks(46, 46);
        n_checks++;
        if (BallX !== 4'd2 || Score1 !== 3'd0 || Score2 !== 3'd0) begin
            n_errors++;
            $display("FAIL p1_hit: got x=%0d sc=%0d:%0d required x=2 sc=0:0",
                     BallX, Score1, Score2);
        end
        run_ticks(47, 47);
        n_checks++;
        if (BallX !== 4'd3) begin
            n_errors++;
            $display("FAIL hit_dx: got x=%0d required 3", BallX);
        end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL rally_tick: got %s required %s", fmt(g), fmt(e));
            end
        end
    endtask

    task automatic test_miss_and_win();
        snap_t e, g;
        run_ticks(48, 73);
        n_checks++;
        if (Score2 !== 3'd1 || State !== 2'd1 || BallX !== 4'd8 || BallY !== 4'd8) begin
            n_errors++;
            $display("FAIL first_miss: got s2=%0d st=%0d ball=(%0d,%0d) required 1 1 (8,8)",
                     Score2, State, BallX, BallY);
        end
        run_ticks(74, 83);
        n_checks++;
        if (Score2 !== 3'd2 || State !== 2'd3 || Winner !== 2'd2) begin
            n_errors++;
            $display("FAIL game_over: got s2=%0d st=%0d win=%0d required 2 3 2",
                     Score2, State, Winner);
        end
        run_ticks(84, 84);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL miss_tick: got %s required %s", fmt(g), fmt(e));
            end
        end
        pulse_enter();
        g = sample();
        n_checks++;
        if (g !== reset_snap()) begin
            n_errors++;
            $display("FAIL restart: got %s required %s", fmt(g), fmt(reset_snap()));
        end
    endtask

    task automatic test_reset_mid_play();
        snap_t e, g;
        pulse_enter();
        run_ticks(0, 3);
        @(negedge Clock);
        Reset = 1'b0;
        @(posedge Clock);
        #1;
        g = sample();
        n_checks++;
        if (g !== reset_snap() || Tick !== 1'b0) begin
            n_errors++;
            $display("FAIL mid_play_reset: got %s tick=%0b required %s tick=0",
                     fmt(g), Tick, fmt(reset_snap()));
        end
        Reset = 1'b1;
        model_reset();
        pulse_enter();
        run_ticks(0, 1);
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.pop_front();
            n_checks++;
            if (g !== e) begin
                n_errors++;
                $display("FAIL replay_tick: got %s required %s", fmt(g), fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_paddles();
        test_p1_hit();
        test_miss_and_win();
        test_reset_mid_play();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
